// File: rtl/bip_prog_loader_if.sv
// bip_prog_loader_if: valid/ready byte stream feeding the program loader
interface bip_prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/bip_prog_loader.sv
// bip_prog_loader: loads a checksummed program image into instruction ROM
// and holds the CPU in reset until a complete, verified image is present.
module bip_prog_loader #(
  parameter int         ADDR_W      = 11,
  parameter int         DATA_W      = 16,
  parameter int         MAX_WORDS   = 2048,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bip_prog_loader_if.slave  rx,
  output logic [ADDR_W-1:0] prog_addr_o,
  output logic [DATA_W-1:0] prog_data_o,
  output logic              prog_we_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR} state_e;
  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d, idx_q, idx_d, word_q, word_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic          xfer, sync, busy;
  assign rx.rx_ready = state_q != WRITE;
  assign xfer        = rx.rx_valid && rx.rx_ready;
  assign sync        = xfer && rx.rx_data == SYNC_BYTE;
  assign busy        = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK};
  assign prog_addr_o = idx_q[ADDR_W-1:0];
  assign prog_data_o = word_q;
  assign prog_we_o   = state_q == WRITE;
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    chk_d   = (busy && xfer && state_q != CHK) ? chk_q ^ rx.rx_data : chk_q;
    timer_d = (busy && !xfer) ? timer_q + 1'b1 : '0;
    case (state_q)
      LEN_HI:  if (xfer) begin
        len_d[15:8] = rx.rx_data;
        state_d     = LEN_LO;
      end
      LEN_LO:  if (xfer) begin
        len_d[7:0] = rx.rx_data;
        state_d    = len_d > 16'(MAX_WORDS) ? ERR : len_d == '0 ? CHK : DATA_HI;
      end
      DATA_HI: if (xfer) begin
        word_d[15:8] = rx.rx_data;
        state_d      = DATA_LO;
      end
      DATA_LO: if (xfer) begin
        word_d[7:0] = rx.rx_data;
        state_d     = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = idx_d == len_q ? CHK : DATA_HI;
      end
      CHK:     if (xfer) state_d = rx.rx_data == chk_q ? DONE : ERR;
      default: if (sync) begin
        state_d = LEN_HI;
        idx_d   = '0;
        chk_d   = '0;
      end
    endcase
    // a stalled stream inside a packet aborts the load
    if (busy && !xfer && timer_q == TW'(TIMEOUT_CYC - 1)) state_d = ERR;
    done_d    = state_d == DONE;
    err_d     = state_d == ERR;
    cpu_rst_d = state_d != DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      timer_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      timer_q   <= timer_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
endmodule
